chunked_adder: RTL and testbench
================================

CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per cycle; WIDTH SHALL be a multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands valid.
REQ-006 SHALL have port in_ready  output  1  block accepts operands.
REQ-007 SHALL have ports a, b  input  WIDTH  operands.
REQ-008 SHALL have port ci  input  1  carry-in (add) / borrow-in (sub).
REQ-009 SHALL have port sub  input  1  1 = subtract, 0 = add.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have ports s  output  WIDTH  sum/difference; co  output  1  carry-out; ovf  output  1  signed overflow; zero  output  1  s == 0.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-014 IDLE: on in_valid && in_ready, SHALL latch a, b, ci, sub, clear chunk counter, go BUSY; in_valid ignored in BUSY/DONE.
REQ-015 BUSY: each edge SHALL add one CHUNK-bit slice, LSB slice first, carry registered between slices; after slice N-1, go DONE.
REQ-016 out_valid SHALL rise exactly N rising edges after the accepting edge.
REQ-017 Add: {co,s} = a + b + ci. Sub: s = a + ~b + !ci (a - b - ci); co = final carry (1 = no borrow).
REQ-018 ovf SHALL be 1 when both effective addends share a sign and s's MSB differs.
REQ-019 s, co, ovf, zero SHALL update only on entry to DONE and hold until next entry to DONE; no intermediate values visible.
REQ-020 DONE: hold outputs while out_ready = 0; on out_ready = 1 go IDLE; new operand not accepted in that same cycle.
REQ-021 Throughput: one operation per N+2 cycles minimum.

Reset
REQ-022 rst SHALL immediately force IDLE, counter 0, out_valid 0, s 0, co 0, ovf 0, zero 0 (zero is 0, not 1, after reset).
REQ-023 rst during BUSY or DONE SHALL abort the operation; no result produced.

Configuration
REQ-024 Macro CHUNKED_ADDER_SUB_EN defined: subtraction per REQ-017.
REQ-025 CHUNKED_ADDER_SUB_EN undefined: sub port present but ignored (treated 0); no inversion logic synthesised.

Structure
REQ-026 Package adder_pkg SHALL hold the FSM state typedef (IDLE/BUSY/DONE) and default WIDTH/CHUNK constants.
REQ-027 Sub-module add_chunk SHALL be a combinational CHUNK-bit ripple adder slice (a, b, ci -> s, co), instantiated once.

Verification (WIDTH=16, CHUNK=4, N=4)
REQ-028 a=0x00FF, b=0x0001, ci=0, sub=0 -> s=0x0100, co=0, ovf=0, zero=0; out_valid 4 edges after accept.
REQ-029 a=0xFFFF, b=0x0001, ci=0 -> s=0x0000, co=1, zero=1, ovf=0; a=0x7FFF, b=0x0001 -> s=0x8000, ovf=1, co=0.
REQ-030 SUB_EN: a=0x0005, b=0x0007, sub=1, ci=0 -> s=0xFFFE, co=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, co=1, ovf=1.
REQ-031 Hold out_ready=0 for 10 cycles in DONE with in_valid=1 -> out_valid, s, flags stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-032 Assert rst after 2 BUSY edges -> out_valid=0, in_ready=1, s=0, flags 0; subsequent operation yields correct result.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and defaults for the chunked (multi-cycle) adder.
// Build option: CHUNKED_ADDER_SUB_EN enables the subtract path.
package adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for n slices, never less than one bit.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice.
// Build option: none (CHUNKED_ADDER_SUB_EN is handled by the top).
module add_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic c;

    always_comb begin
        c = ci;
        s = '0;
        for (int i = 0; i < CHUNK; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, LSB first.
// Build option: CHUNKED_ADDER_SUB_EN enables subtraction via the sub port.
module chunked_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = cnt_bits(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic             a_msb;
    logic             b_msb;

    logic [WIDTH-1:0] b_in;
    logic             ci_in;
    logic [CHUNK-1:0] slice_s;
    logic             slice_co;
    logic [WIDTH+CHUNK-1:0] cat;
    logic [WIDTH-1:0] res_next;
    logic             last;

    // Subtraction is folded into the operands at accept time:
    // a - b - ci == a + ~b + !ci.
`ifdef CHUNKED_ADDER_SUB_EN
    assign b_in  = sub ? ~b : b;
    assign ci_in = sub ? ~ci : ci;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_in  = b;
    assign ci_in = ci;
`endif

    add_chunk #(
        .CHUNK(CHUNK)
    ) u_slice (
        .a (a_q[CHUNK-1:0]),
        .b (b_q[CHUNK-1:0]),
        .ci(carry),
        .s (slice_s),
        .co(slice_co)
    );

    // New slice enters at the top; after N steps slice 0 sits at the bottom.
    assign cat      = {slice_s, acc};
    assign res_next = cat[WIDTH+CHUNK-1:CHUNK];
    assign last     = (cnt == LAST);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            s     <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b_in;
                        carry <= ci_in;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b_in[WIDTH-1];
                        cnt   <= '0;
                        acc   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    a_q   <= a_q >> CHUNK;
                    b_q   <= b_q >> CHUNK;
                    acc   <= res_next;
                    carry <= slice_co;
                    cnt   <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        state <= DONE;
                        s     <= res_next;
                        co    <= slice_co;
                        ovf   <= (a_msb == b_msb) &&
                                 (res_next[WIDTH-1] != a_msb);
                        zero  <= (res_next == '0);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder (WIDTH=16, CHUNK=4).
// Sub vectors follow CHUNKED_ADDER_SUB_EN when the build defines it.
module tb_chunked_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        co;
    logic        ovf;
    logic        zero;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] s;
        logic        co;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sub;
        res_t        exp;
    } vec_t;

    vec_t vecs[$];

    chunked_adder #(
        .WIDTH(16),
        .CHUNK(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .ci       (ci),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .co       (co),
        .ovf      (ovf),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Integer-arithmetic reference: signed range for ovf, unsigned for co.
    function automatic res_t model(input logic [15:0] ma,
                                   input logic [15:0] mb,
                                   input logic mci, input logic msub);
        res_t r;
        int   u;
        int   sv;
        logic do_sub;
`ifdef CHUNKED_ADDER_SUB_EN
        do_sub = msub;
`else
        do_sub = 1'b0;
        if (msub) do_sub = 1'b0;
`endif
        if (do_sub) begin
            u    = int'(ma) - int'(mb) - int'(mci);
            sv   = int'($signed(ma)) - int'($signed(mb)) - int'(mci);
            r.co = (u >= 0);
        end else begin
            u    = int'(ma) + int'(mb) + int'(mci);
            sv   = int'($signed(ma)) + int'($signed(mb)) + int'(mci);
            r.co = (u > 65535);
        end
        r.s    = u[15:0];
        r.ovf  = (sv > 32767) || (sv < -32768);
        r.zero = (r.s == 16'h0000);
        return r;
    endfunction

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic run_op(input string name, input logic [15:0] ta,
                          input logic [15:0] tb, input logic tci,
                          input logic tsub, input res_t exp);
        int lat;
        chk({name, ".in_ready"}, 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb;
        ci       = tci;
        sub      = tsub;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, ".latency"}, 32'(lat), 32'd4);
        chk({name, ".s"}, 32'(s), 32'(exp.s));
        chk({name, ".co"}, 32'(co), 32'(exp.co));
        chk({name, ".ovf"}, 32'(ovf), 32'(exp.ovf));
        chk({name, ".zero"}, 32'(zero), 32'(exp.zero));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, ".back_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rci;
        logic        rsub;
        res_t        hold;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        sub       = 1'b0;

        vecs.push_back('{16'h00FF, 16'h0001, 1'b0, 1'b0,
                         '{16'h0100, 1'b0, 1'b0, 1'b0}});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0,
                         '{16'h0000, 1'b1, 1'b0, 1'b1}});
        vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0,
                         '{16'h8000, 1'b0, 1'b1, 1'b0}});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0,
                         '{16'h0000, 1'b1, 1'b1, 1'b1}});
        vecs.push_back('{16'h1234, 16'h0000, 1'b1, 1'b0,
                         '{16'h1235, 1'b0, 1'b0, 1'b0}});
`ifdef CHUNKED_ADDER_SUB_EN
        vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1,
                         '{16'hFFFE, 1'b0, 1'b0, 1'b0}});
        vecs.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1,
                         '{16'h7FFF, 1'b1, 1'b1, 1'b0}});
`else
        vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1,
                         '{16'h000C, 1'b0, 1'b0, 1'b0}});
`endif

        #12;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.s", 32'(s), 32'd0);
        chk("rst.co", 32'(co), 32'd0);
        chk("rst.ovf", 32'(ovf), 32'd0);
        chk("rst.zero", 32'(zero), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].ci, vecs[i].sub, vecs[i].exp);
        end

        // Hold in DONE with a competing operand offered.
        run_op("pre_hold", 16'h1234, 16'h1111, 1'b0, 1'b0,
               '{16'h2345, 1'b0, 1'b0, 1'b0});
        a        = 16'h1234;
        b        = 16'h1111;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 16'h0F0F;
        b = 16'h7777;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
        end
        chk("hold.entered", 32'(out_valid), 32'd1);
        hold = model(16'h1234, 16'h1111, 1'b0, 1'b0);
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            chk("hold.out_valid", 32'(out_valid), 32'd1);
            chk("hold.in_ready", 32'(in_ready), 32'd0);
            chk("hold.res", 32'({s, co, ovf, zero}), 32'(hold));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release.in_ready", 32'(in_ready), 32'd1);
        chk("release.out_valid", 32'(out_valid), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("release.no_accept", 32'(in_ready), 32'd1);

        // Reset mid-operation, after two BUSY edges.
        a        = 16'h4321;
        b        = 16'h1111;
        ci       = 1'b0;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort.out_valid", 32'(out_valid), 32'd0);
        chk("abort.in_ready", 32'(in_ready), 32'd1);
        chk("abort.s", 32'(s), 32'd0);
        chk("abort.flags", 32'({co, ovf, zero}), 32'd0);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk);
            #1;
            chk("abort.no_result", 32'(out_valid), 32'd0);
        end
        run_op("post_abort", 16'h4321, 16'h1111, 1'b0, 1'b0,
               '{16'h5432, 1'b0, 1'b0, 1'b0});

        for (int i = 0; i < 40; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rci  = 1'($urandom);
            rsub = 1'($urandom);
            if (i % 8 == 0) rb = 16'h0000 - ra - 16'(rci);
            run_op($sformatf("rnd%0d", i), ra, rb, rci, rsub,
                   model(ra, rb, rci, rsub));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
